hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Sequences the in-order pipeline around the instruction decode stage.
- Detects load-use hazards on the decode stage's rs1/rs2 addresses and stalls the PC and IF/ID registers.
- Drives ctrl_hazard, which zeroes the control word issued to ID/EX.
- Flushes wrong-path instructions on a taken branch and freezes the whole pipeline while data memory is busy.

Parameters:
- LOAD_LATENCY, 1, bubble cycles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX flush stays asserted after a taken branch (1..7).
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1_addr  in  REG_ADDR_W  rs1 of instruction in ID.
- id_rs2_addr  in  REG_ADDR_W  rs2 of instruction in ID.
- id_uses_rs2  in  1  instruction in ID reads rs2 (R-type, store, branch).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd_addr  in  REG_ADDR_W  destination of instruction in EX.
- branch_taken  in  1  taken branch resolved in MEM this cycle.
- mem_busy  in  1  data memory not ready; pipeline must freeze.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX, EX/MEM and MEM/WB enable.
- ctrl_hazard  out  1  force all decode control outputs to 0 (bubble).
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX to NOP.

Behaviour:
- FSM states: RUN, LU_STALL, FLUSH. Counter cnt is $clog2(8) bits wide.
- All outputs are combinational from state, cnt and inputs, so a stall acts in the same cycle the hazard is seen.
- Reset (rst=1 at edge): state RUN, cnt 0.
  - While rst=1, outputs are forced to pc_write=0, if_id_write=0, id_ex_write=0, ctrl_hazard=1, if_id_flush=1, id_ex_flush=1.
  - Reset mid-stall or mid-flush abandons the sequence.
- Hazard condition lu: id_valid & ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | (id_uses_rs2 & ex_rd_addr==id_rs2_addr)).
  - ex_rd_addr==0 never stalls.
- Priority each cycle: rst > mem_busy > branch_taken > lu.
- mem_busy=1 in any state:
  - Outputs: pc_write=0, if_id_write=0, id_ex_write=0, ctrl_hazard=0, both flushes 0.
  - state and cnt hold.
  - branch_taken and lu are ignored; they are re-evaluated after release because the pipeline registers are frozen.
- Default RUN with no event: pc_write=1, if_id_write=1, id_ex_write=1, ctrl_hazard=0, flushes 0.
- branch_taken=1 (RUN or LU_STALL):
  - Outputs: pc_write=1 (loads target), if_id_write=1, id_ex_write=1, if_id_flush=1, id_ex_flush=1, ctrl_hazard=1.
  - If FLUSH_CYCLES>1: next state FLUSH, cnt=FLUSH_CYCLES-1. Otherwise next state RUN.
  - A branch aborts any pending load-use stall.
- lu=1 in RUN:
  - Outputs: pc_write=0, if_id_write=0, ctrl_hazard=1, id_ex_write=1, flushes 0.
  - If LOAD_LATENCY>1: next state LU_STALL, cnt=LOAD_LATENCY-1. Otherwise stay in RUN.
- LU_STALL: same outputs as lu.
  - Decrement cnt each cycle; at cnt==1 return to RUN.
  - lu is not re-evaluated inside LU_STALL.
- FLUSH: same outputs as branch_taken, but branch_taken is ignored.
  - Decrement cnt each cycle; at cnt==1 return to RUN.
- Back-to-back: a second load-use hazard seen in RUN on the cycle right after LU_STALL exits starts a new stall.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both cleared by rst.
  - stall_cycles increments on every cycle with ctrl_hazard=1 and both flushes 0.
  - flush_events increments once per accepted branch_taken, not per FLUSH cycle.
  - Both counters hold during mem_busy and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ex_mem_read=1, ex_rd_addr=5, id_rs1_addr=5, id_valid=1, LOAD_LATENCY=1 -> exactly 1 cycle of pc_write=0, if_id_write=0, ctrl_hazard=1, then RUN outputs.
- Same as above with ex_rd_addr=0, or with a match only on rs2 and id_uses_rs2=0 -> no stall; pc_write stays 1.
- LOAD_LATENCY=3, hazard on rs2=7 with id_uses_rs2=1 -> 3 stall cycles; branch_taken in stall cycle 2 -> flushes=1 that cycle, stall aborted, pc_write=1.
- FLUSH_CYCLES=2, branch_taken pulse -> if_id_flush and id_ex_flush high for 2 consecutive cycles, then low.
- mem_busy high for 4 cycles during LU_STALL cnt=2 -> all write enables 0 for 4 cycles; the stall then resumes with its 2 remaining cycles.
- rst asserted mid-FLUSH -> reset outputs on that cycle; RUN outputs the cycle after rst deasserts. With HAZARD_PERF_EN: counters read 0.

Source files
------------

// File: rtl/hazard_controller.sv
// Load-use stall, branch flush and memory-busy freeze sequencing around ID.
// Optional HAZARD_PERF_EN adds stall_cycles/flush_events performance counters.
module hazard_controller #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  ctrl_hazard,
  output logic                  if_id_flush,
  output logic                  id_ex_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam int unsigned CNT_W = $clog2(8);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Entry state/count for each sequence; single-cycle variants stay in RUN.
  localparam state_e            LU_STATE = (LOAD_LATENCY > 1) ? LU_STALL : RUN;
  localparam logic [CNT_W-1:0] LU_CNT    = (LOAD_LATENCY > 1) ? CNT_W'(LOAD_LATENCY - 1) : '0;
  localparam state_e            BR_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  localparam logic [CNT_W-1:0] BR_CNT    = (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lu;
  logic             flush_sel;
  logic             stall_sel;

  assign lu = id_valid && ex_mem_read && (ex_rd_addr != '0) &&
              ((ex_rd_addr == id_rs1_addr) || (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));

  // Branch wins over a stall; FLUSH state ignores new branches.
  assign flush_sel = (state_q == FLUSH) || branch_taken;
  assign stall_sel = (state_q == LU_STALL) || lu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (!mem_busy) begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            state_q <= BR_STATE;
            cnt_q   <= BR_CNT;
          end else if (lu) begin
            state_q <= LU_STATE;
            cnt_q   <= LU_CNT;
          end
        end
        LU_STALL: begin
          if (branch_taken) begin
            state_q <= BR_STATE;
            cnt_q   <= BR_CNT;
          end else if (cnt_q == CNT_W'(1)) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FLUSH: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    ctrl_hazard = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ctrl_hazard = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else if (flush_sel) begin
      ctrl_hazard = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall_sel) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_hazard = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Branches count once on acceptance, not per FLUSH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (!mem_busy) begin
      if (ctrl_hazard && !if_id_flush && !id_ex_flush) stall_q <= stall_q + 32'd1;
      if (branch_taken && (state_q != FLUSH))          flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: instance A (LOAD_LATENCY=3, FLUSH_CYCLES=2) and B (both 1) share stimulus.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;

  logic pc_a, ifid_a, idex_a, ctrl_a, iff_a, idf_a;
  logic pc_b, ifid_b, idex_b, ctrl_b, iff_b, idf_b;
  logic [5:0] oa, ob;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] O_RST   = 6'b000111;
  localparam logic [5:0] O_RUN   = 6'b111000;
  localparam logic [5:0] O_STALL = 6'b001100;
  localparam logic [5:0] O_FLUSH = 6'b111111;
  localparam logic [5:0] O_BUSY  = 6'b000000;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_LATENCY(3), .FLUSH_CYCLES(2), .REG_ADDR_W(5)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_a), .if_id_write(ifid_a), .id_ex_write(idex_a), .ctrl_hazard(ctrl_a),
    .if_id_flush(iff_a), .id_ex_flush(idf_a)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_a), .flush_events(flush_a)
`endif
  );

  hazard_controller #(.LOAD_LATENCY(1), .FLUSH_CYCLES(1), .REG_ADDR_W(5)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_b), .if_id_write(ifid_b), .id_ex_write(idex_b), .ctrl_hazard(ctrl_b),
    .if_id_flush(iff_b), .id_ex_flush(idf_b)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_b), .flush_events(flush_b)
`endif
  );

  assign oa = {pc_a, ifid_a, idex_a, ctrl_a, iff_a, idf_a};
  assign ob = {pc_b, ifid_b, idex_b, ctrl_b, iff_b, idf_b};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    chk({tag, "_A"}, 32'(oa), 32'(ea));
    chk({tag, "_B"}, 32'(ob), 32'(eb));
  endtask

  task automatic set_in(input logic r, input logic v, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic br, input logic busy);
    rst          = r;
    id_valid     = v;
    ex_mem_read  = mr;
    ex_rd_addr   = rd;
    id_rs1_addr  = rs1;
    id_rs2_addr  = rs2;
    id_uses_rs2  = u2;
    branch_taken = br;
    mem_busy     = busy;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_both("reset", O_RST, O_RST); cyc();
    idle(); chk_both("idle", O_RUN, O_RUN); cyc();

    // Load-use on rs1: B stalls once, A three times.
    set_in(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_both("lu1", O_STALL, O_STALL); cyc();
    idle(); chk_both("lu2", O_STALL, O_RUN); cyc();
    idle(); chk_both("lu3", O_STALL, O_RUN); cyc();
    idle(); chk_both("lu_end", O_RUN, O_RUN); cyc();

    set_in(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_both("rd_zero", O_RUN, O_RUN); cyc();
    set_in(1'b0, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    chk_both("rs2_unused", O_RUN, O_RUN); cyc();

    // rs2 hazard, then branch in stall cycle 2 aborts it.
    set_in(1'b0, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    chk_both("rs2_lu", O_STALL, O_STALL); cyc();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk_both("abort", O_FLUSH, O_FLUSH); cyc();
    idle(); chk_both("abort_fl2", O_FLUSH, O_RUN); cyc();
    idle(); chk_both("abort_end", O_RUN, O_RUN); cyc();

    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk_both("br1", O_FLUSH, O_FLUSH); cyc();
    idle(); chk_both("br2", O_FLUSH, O_RUN); cyc();
    idle(); chk_both("br3", O_RUN, O_RUN); cyc();

    // Freeze for 4 cycles at LU_STALL cnt=2; a branch during busy is ignored.
    set_in(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_both("busy_lu", O_STALL, O_STALL); cyc();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i == 1), 1'b1);
      chk_both("busy", O_BUSY, O_BUSY); cyc();
    end
    idle(); chk_both("resume1", O_STALL, O_RUN); cyc();
    idle(); chk_both("resume2", O_STALL, O_RUN); cyc();
    idle(); chk_both("resume_end", O_RUN, O_RUN); cyc();

    // Held hazard: A restarts a stall right after LU_STALL exits.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_both("b2b", O_STALL, O_STALL); cyc();
    end
    idle(); chk_both("b2b_tail", O_STALL, O_RUN); cyc();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk_both("pre_rst_br", O_FLUSH, O_FLUSH); cyc();

    // Reset in the middle of A's FLUSH sequence.
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_both("mid_flush_rst", O_RST, O_RST);
`ifdef HAZARD_PERF_EN
    chk("stall_A", stall_a, 32'd12);
    chk("flush_A", flush_a, 32'd3);
    chk("stall_B", stall_b, 32'd7);
    chk("flush_B", flush_b, 32'd3);
`endif
    cyc();
    idle(); chk_both("after_rst", O_RUN, O_RUN);
`ifdef HAZARD_PERF_EN
    chk("stall_A_rst", stall_a, 32'd0);
    chk("flush_A_rst", flush_a, 32'd0);
    chk("stall_B_rst", stall_b, 32'd0);
    chk("flush_B_rst", flush_b, 32'd0);
`endif
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
